// File: rtl/uart_reg_bridge_32bit_pkg.sv
// Shared definitions for the UART command-to-register bridge.
// FSM state encoding and the command/response byte codes.
package uart_reg_bridge_32bit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_ACCESS,
        ST_WAIT_RD,
        ST_RSP
    } state_t;

    localparam logic [7:0] CMD_WR    = 8'h01;
    localparam logic [7:0] CMD_RD    = 8'h02;
    localparam logic [7:0] RSP_WR_OK = 8'h00;
    localparam logic [7:0] RSP_RD_OK = 8'h01;
    localparam logic [7:0] RSP_TMO   = 8'hFF;

endpackage

// File: rtl/uart_bridge_timeout_cnt.sv
// Clear/enable cycle counter; flags expiry on the LIMIT-th
// consecutive enabled cycle without a clear.
module uart_bridge_timeout_cnt #(
    parameter logic [31:0] LIMIT = 32'd500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    logic [31:0] r_cnt;

    assign o_expire = i_en && !i_clr && (r_cnt == LIMIT - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en || o_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/uart_reg_bridge_32bit.sv
// Decodes framed read/write commands from the UART RX FIFO into
// 32-bit local-bus accesses and returns responses through the TX FIFO.
module uart_reg_bridge_32bit
    import uart_reg_bridge_32bit_pkg::*;
#(
    parameter int          ADDR_W      = 16,
    parameter logic [31:0] TIMEOUT_CYC = 32'd500000,
    parameter logic [7:0]  SOF_BYTE    = 8'hA5,
    parameter logic [7:0]  RSP_BYTE    = 8'h5A
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_rd_data,
    input  logic              rx_rd_valid,
    output logic              rx_rd_req,
    output logic [7:0]        tx_wr_data,
    output logic              tx_wr_req,
    input  logic              tx_wr_ready,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_wr_en,
    output logic [31:0]       reg_wr_data,
    output logic              reg_rd_en,
    input  logic [31:0]       reg_rd_data,
    input  logic              reg_rd_valid,
    output logic              frm_err
);

    state_t            r_state, w_state_n;
    logic [1:0]        r_cnt, w_cnt_n;
    logic              r_is_rd, w_is_rd_n;
    logic              r_data_ph, w_data_ph_n;
    logic              r_run;
    logic [ADDR_W-1:0] r_addr, w_addr_n;
    logic [31:0]       r_wdata, w_wdata_n;
    logic [31:0]       r_rdata, w_rdata_n;
    logic [7:0]        r_status, w_status_n;
    logic [7:0]        r_tx_data, w_tx_data_n;
    logic              r_tx_req, w_tx_req_n;
    logic              r_wr_en, w_wr_en_n;
    logic              r_rd_en, w_rd_en_n;
    logic              r_err, w_err_n;
    logic              w_rx_phase, w_pop, w_tmr_en, w_expire;

    // r_run keeps the RX pop off while reset is held or just released
    assign w_rx_phase = (r_state == ST_IDLE) || (r_state == ST_CMD) ||
                        (r_state == ST_ADDR) || (r_state == ST_WDATA);
    assign rx_rd_req  = r_run && rx_rd_valid && w_rx_phase;
    assign w_pop      = rx_rd_req;
    assign w_tmr_en   = (w_rx_phase && r_state != ST_IDLE) ||
                        (r_state == ST_WAIT_RD);

    assign tx_wr_data  = r_tx_data;
    assign tx_wr_req   = r_tx_req;
    assign reg_addr    = r_addr;
    assign reg_wr_en   = r_wr_en;
    assign reg_wr_data = r_wdata;
    assign reg_rd_en   = r_rd_en;
    assign frm_err     = r_err;

    uart_bridge_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_pop),
        .i_en     (w_tmr_en),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_is_rd_n   = r_is_rd;
        w_data_ph_n = r_data_ph;
        w_addr_n    = r_addr;
        w_wdata_n   = r_wdata;
        w_rdata_n   = r_rdata;
        w_status_n  = r_status;
        w_tx_data_n = r_tx_data;
        w_tx_req_n  = r_tx_req;
        w_wr_en_n   = 1'b0;
        w_rd_en_n   = 1'b0;
        w_err_n     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_pop && rx_rd_data == SOF_BYTE) w_state_n = ST_CMD;
            end
            ST_CMD: begin
                if (w_pop) begin
                    if (rx_rd_data == CMD_WR || rx_rd_data == CMD_RD) begin
                        w_is_rd_n = (rx_rd_data == CMD_RD);
                        w_cnt_n   = 2'd0;
                        w_state_n = ST_ADDR;
                    end else begin
                        w_err_n   = 1'b1;
                        w_state_n = ST_IDLE;
                    end
                end else if (w_expire) begin
                    w_err_n   = 1'b1;
                    w_state_n = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (w_pop) begin
                    w_addr_n = {r_addr[ADDR_W-9:0], rx_rd_data};
                    if (r_cnt == 2'd1) begin
                        w_cnt_n   = 2'd0;
                        w_rd_en_n = r_is_rd;
                        w_state_n = r_is_rd ? ST_ACCESS : ST_WDATA;
                    end else begin
                        w_cnt_n = r_cnt + 2'd1;
                    end
                end else if (w_expire) begin
                    w_err_n   = 1'b1;
                    w_state_n = ST_IDLE;
                end
            end
            ST_WDATA: begin
                if (w_pop) begin
                    w_wdata_n = {r_wdata[23:0], rx_rd_data};
                    if (r_cnt == 2'd3) begin
                        w_wr_en_n = 1'b1;
                        w_state_n = ST_ACCESS;
                    end else begin
                        w_cnt_n = r_cnt + 2'd1;
                    end
                end else if (w_expire) begin
                    w_err_n   = 1'b1;
                    w_state_n = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (r_is_rd) begin
                    w_state_n = ST_WAIT_RD;
                end else begin
                    w_status_n  = RSP_WR_OK;
                    w_state_n   = ST_RSP;
                    w_cnt_n     = 2'd0;
                    w_data_ph_n = 1'b0;
                    w_tx_req_n  = 1'b1;
                    w_tx_data_n = RSP_BYTE;
                end
            end
            ST_WAIT_RD: begin
                if (reg_rd_valid || w_expire) begin
                    w_rdata_n   = reg_rd_data;
                    w_status_n  = reg_rd_valid ? RSP_RD_OK : RSP_TMO;
                    w_err_n     = !reg_rd_valid;
                    w_state_n   = ST_RSP;
                    w_cnt_n     = 2'd0;
                    w_data_ph_n = 1'b0;
                    w_tx_req_n  = 1'b1;
                    w_tx_data_n = RSP_BYTE;
                end
            end
            ST_RSP: begin
                // header phase sends 2 bytes; data phase drains r_rdata MSB first
                if (r_tx_req && tx_wr_ready) begin
                    if (!r_data_ph && r_cnt == 2'd0) begin
                        w_cnt_n     = 2'd1;
                        w_tx_data_n = r_status;
                    end else if (!r_data_ph && r_status == RSP_RD_OK) begin
                        w_data_ph_n = 1'b1;
                        w_cnt_n     = 2'd0;
                        w_tx_data_n = r_rdata[31:24];
                    end else if (r_data_ph && r_cnt != 2'd3) begin
                        w_cnt_n     = r_cnt + 2'd1;
                        w_rdata_n   = {r_rdata[23:0], 8'h00};
                        w_tx_data_n = r_rdata[23:16];
                    end else begin
                        w_tx_req_n  = 1'b0;
                        w_tx_data_n = 8'h00;
                        w_state_n   = ST_IDLE;
                    end
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 2'd0;
            r_is_rd   <= 1'b0;
            r_data_ph <= 1'b0;
            r_run     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_status  <= '0;
            r_tx_data <= '0;
            r_tx_req  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_is_rd   <= w_is_rd_n;
            r_data_ph <= w_data_ph_n;
            r_run     <= 1'b1;
            r_addr    <= w_addr_n;
            r_wdata   <= w_wdata_n;
            r_rdata   <= w_rdata_n;
            r_status  <= w_status_n;
            r_tx_data <= w_tx_data_n;
            r_tx_req  <= w_tx_req_n;
            r_wr_en   <= w_wr_en_n;
            r_rd_en   <= w_rd_en_n;
            r_err     <= w_err_n;
        end
    end

endmodule

// File: tb/tb_uart_reg_bridge_32bit.sv
// Scoreboard bench for uart_reg_bridge_32bit: FIFO/bus models drive
// the DUT, a negedge monitor pops expected bytes/strobes and compares.
module tb_uart_reg_bridge_32bit;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_rd_data = 8'h00;
    logic        rx_rd_valid = 1'b0;
    logic        rx_rd_req;
    logic [7:0]  tx_wr_data;
    logic        tx_wr_req;
    logic        tx_wr_ready = 1'b1;
    logic [15:0] reg_addr;
    logic        reg_wr_en;
    logic [31:0] reg_wr_data;
    logic        reg_rd_en;
    logic [31:0] reg_rd_data = 32'h0;
    logic        reg_rd_valid = 1'b0;
    logic        frm_err;

    always #5 clk = ~clk;

    uart_reg_bridge_32bit #(.TIMEOUT_CYC(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_rd_data   (rx_rd_data),
        .rx_rd_valid  (rx_rd_valid),
        .rx_rd_req    (rx_rd_req),
        .tx_wr_data   (tx_wr_data),
        .tx_wr_req    (tx_wr_req),
        .tx_wr_ready  (tx_wr_ready),
        .reg_addr     (reg_addr),
        .reg_wr_en    (reg_wr_en),
        .reg_wr_data  (reg_wr_data),
        .reg_rd_en    (reg_rd_en),
        .reg_rd_data  (reg_rd_data),
        .reg_rd_valid (reg_rd_valid),
        .frm_err      (frm_err)
    );

    logic [7:0]  rx_q[$];
    logic [7:0]  tx_exp[$];
    logic [15:0] wr_exp_a[$];
    logic [31:0] wr_exp_d[$];
    logic [15:0] rd_exp_a[$];

    int          checks = 0;
    int          failures = 0;
    int          err_seen = 0;
    int          err_exp = 0;
    int          cyc = 0;
    int          last_pop_cyc = 0;
    int          rd_lat = 0;
    int          rd_cnt = 0;
    logic [31:0] rd_val = 32'h0;
    bit          busy = 1'b0;
    bit          tog_mode = 1'b0;
    bit          pop_pend = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // monitor: sample away from the active edge
    always @(negedge clk) begin
        cyc++;
        pop_pend = 1'b0;
        if (rst_n) begin
            if (reg_wr_en || reg_rd_en) busy = 1'b1;
            if (rx_rd_req && rx_rd_valid) begin
                pop_pend = 1'b1;
                chk("rx_pop_while_busy", 32'(busy), 32'd0);
                last_pop_cyc = cyc;
            end
            if (reg_wr_en) begin
                chk("wr_expected", 32'(wr_exp_a.size() > 0), 32'd1);
                chk("wr_latency", 32'(cyc - last_pop_cyc), 32'd1);
                if (wr_exp_a.size() > 0) begin
                    chk("wr_addr", 32'(reg_addr), 32'(wr_exp_a.pop_front()));
                    chk("wr_data", reg_wr_data, wr_exp_d.pop_front());
                end
            end
            if (reg_rd_en) begin
                chk("rd_expected", 32'(rd_exp_a.size() > 0), 32'd1);
                chk("rd_latency", 32'(cyc - last_pop_cyc), 32'd1);
                if (rd_exp_a.size() > 0)
                    chk("rd_addr", 32'(reg_addr), 32'(rd_exp_a.pop_front()));
                rd_cnt = rd_lat;
            end
            if (tx_wr_req && tx_wr_ready) begin
                chk("tx_expected", 32'(tx_exp.size() > 0), 32'd1);
                if (tx_exp.size() > 0)
                    chk("tx_byte", 32'(tx_wr_data), 32'(tx_exp.pop_front()));
                if (tx_exp.size() == 0) busy = 1'b0;
            end
            if (frm_err) err_seen++;
        end
    end

    // RX FIFO, TX ready and register slave models
    always @(posedge clk) begin
        #1;
        if (pop_pend) void'(rx_q.pop_front());
        rx_rd_valid = (rx_q.size() > 0);
        rx_rd_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        tx_wr_ready = tog_mode ? ~tx_wr_ready : 1'b1;
        reg_rd_valid = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                reg_rd_valid = 1'b1;
                reg_rd_data  = rd_val;
            end
        end
    end

    task automatic send(input logic [7:0] b[$]);
        @(negedge clk);
        #2;
        foreach (b[i]) rx_q.push_back(b[i]);
    endtask

    task automatic drain(input string nm, input int max_cyc);
        int n = 0;
        while ((rx_q.size() + tx_exp.size() + wr_exp_a.size() +
                rd_exp_a.size()) != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk(nm, rx_q.size() + tx_exp.size() + wr_exp_a.size() +
                rd_exp_a.size(), 32'd0);
        repeat (3) @(negedge clk);
        chk({nm, "_frm_err"}, err_seen, err_exp);
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_rx_rd_req"}, 32'(rx_rd_req), 0);
        chk({nm, "_tx_wr_req"}, 32'(tx_wr_req), 0);
        chk({nm, "_tx_wr_data"}, 32'(tx_wr_data), 0);
        chk({nm, "_reg_addr"}, 32'(reg_addr), 0);
        chk({nm, "_reg_wr_en"}, 32'(reg_wr_en), 0);
        chk({nm, "_reg_wr_data"}, reg_wr_data, 0);
        chk({nm, "_reg_rd_en"}, 32'(reg_rd_en), 0);
        chk({nm, "_frm_err"}, 32'(frm_err), 0);
    endtask

    initial begin
        int n;
        // reset: a byte waiting in RX must not be popped
        send('{8'h00});
        repeat (3) @(negedge clk);
        chk("rst_rx_valid_seen", 32'(rx_rd_valid), 32'd1);
        chk_reset_outs("rst");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // 1: write
        wr_exp_a.push_back(16'h0010);
        wr_exp_d.push_back(32'hDEADBEEF);
        tx_exp = '{8'h5A, 8'h00};
        send('{8'hA5, 8'h01, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
        drain("t1_write", 200);

        // 2: read, data 3 cycles after strobe
        rd_lat = 3;
        rd_val = 32'h12345678;
        rd_exp_a.push_back(16'h0020);
        tx_exp = '{8'h5A, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        send('{8'hA5, 8'h02, 8'h00, 8'h20});
        drain("t2_read", 200);

        // 3: garbage, bad CMD, then good read
        rd_val = 32'hCAFEF00D;
        err_exp++;
        rd_exp_a.push_back(16'h0030);
        tx_exp = '{8'h5A, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        send('{8'h00, 8'hFF, 8'hA5, 8'h07, 8'hA5, 8'h02, 8'h00, 8'h30});
        drain("t3_badcmd", 200);

        // 4: inter-byte timeout, then a good write
        send('{8'hA5, 8'h01, 8'h00});
        drain("t4_partial", 50);
        err_exp++;
        repeat (TMO + 10) @(negedge clk);
        chk("t4_tmo_frm_err", err_seen, err_exp);
        wr_exp_a.push_back(16'h1234);
        wr_exp_d.push_back(32'h00000001);
        tx_exp = '{8'h5A, 8'h00};
        send('{8'hA5, 8'h01, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h01});
        drain("t4_after", 200);

        // 5: read data never arrives
        rd_lat = 0;
        err_exp++;
        rd_exp_a.push_back(16'h0040);
        tx_exp = '{8'h5A, 8'hFF};
        send('{8'hA5, 8'h02, 8'h00, 8'h40});
        drain("t5_rd_tmo", 300);

        // 6: TX back-pressure, trailing byte must wait
        rd_lat = 2;
        rd_val = 32'hA1B2C3D4;
        tog_mode = 1'b1;
        rd_exp_a.push_back(16'h0050);
        tx_exp = '{8'h5A, 8'h01, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send('{8'hA5, 8'h02, 8'h00, 8'h50, 8'h33});
        drain("t6_backpress", 300);
        tog_mode = 1'b0;

        // 7: reset mid-frame, then a write must decode from scratch
        send('{8'hA5, 8'h02, 8'h00});
        n = 0;
        while (rx_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t7_consumed", rx_q.size(), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        busy = 1'b0;
        rd_cnt = 0;
        @(negedge clk);
        chk_reset_outs("t7_rst");
        @(posedge clk);
        #2 rst_n = 1'b1;
        wr_exp_a.push_back(16'h0060);
        wr_exp_d.push_back(32'h11223344);
        tx_exp = '{8'h5A, 8'h00};
        send('{8'hA5, 8'h01, 8'h00, 8'h60, 8'h11, 8'h22, 8'h33, 8'h44});
        drain("t7_after_rst", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
